// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcode and
// funct values, ALU control codes and ALU operand-B selects.
package multicycle_control_unit_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_ADDIEXEC = 4'd8,
    S_ADDIWB   = 4'd9,
    S_BRANCH   = 4'd10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// R-type funct decoder: maps Funct to an ALU control code and flags unsupported
// funct values (which fall back to ADD).
module alu_decoder
  import multicycle_control_unit_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [3:0] alu_control_o,
  output logic       illegal_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    illegal_o     = 1'b0;
    case (funct_i)
      FN_AND:  alu_control_o = ALU_AND;
      FN_OR:   alu_control_o = ALU_OR;
      FN_NOR:  alu_control_o = ALU_NOR;
      FN_ADD:  alu_control_o = ALU_ADD;
      FN_SUB:  alu_control_o = ALU_SUB;
      FN_SLT:  alu_control_o = ALU_SLT;
      default: illegal_o     = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// writeback, with combinational PCWrite in BRANCH and Funct-driven ALU op in EXECUTE.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       initial_sel,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       PCSrc,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic       illegal_o
);

  state_e     state_q, state_d;
  logic       initial_sel_q;
  logic [3:0] dec_alu;
  logic       dec_illegal;
  logic       pcwrite_s, memwrite_s, irwrite_s, regwrite_s, illegal_s;

  // DATA_WIDTH only documents the datapath width; this guard keeps it referenced.
  if (DATA_WIDTH > 0) begin : g_dec
    alu_decoder u_alu_decoder (
      .funct_i      (Funct),
      .alu_control_o(dec_alu),
      .illegal_o    (dec_illegal)
    );
  end else begin : g_nodec
    assign dec_alu     = ALU_ADD;
    assign dec_illegal = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      initial_sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) initial_sel_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pcwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    illegal_s  = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    PCSrc      = 1'b0;
    ALUSrcB    = SRCB_REG;
    ALUControl = ALU_AND;
    case (state_q)
      S_FETCH: begin
        irwrite_s  = 1'b1;
        pcwrite_s  = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ALUControl = ALU_ADD;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        ALUSrcB    = SRCB_IMMSH;
        ALUControl = ALU_ADD;
        case (OP)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_BEQ:       state_d = S_BRANCH;
          default: begin
            state_d   = S_FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = ALU_ADD;
        state_d    = (OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        regwrite_s = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        IorD       = 1'b1;
        memwrite_s = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUControl = dec_alu;
        illegal_s  = dec_illegal;
        state_d    = dec_illegal ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        regwrite_s = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = ALU_ADD;
        state_d    = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_s = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 1'b1;
        pcwrite_s  = Zero;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write strobes are suppressed for as long as reset is held.
  assign PCWrite     = pcwrite_s  & ~reset;
  assign MemWrite    = memwrite_s & ~reset;
  assign IRWrite     = irwrite_s  & ~reset;
  assign RegWrite    = regwrite_s & ~reset;
  assign illegal_o   = illegal_s  & ~reset;
  assign initial_sel = initial_sel_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected output sequences
// built from the instruction class, compared cycle by cycle.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OP, Funct;
  logic       Zero;
  logic       initial_sel, PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg;
  logic       RegWrite, ALUSrcA, PCSrc, illegal_o;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl;

  int errors = 0;
  int checks = 0;
  bit init_done;
  logic [16:0] exp_q[$];

  multicycle_control_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero),
    .initial_sel(initial_sel), .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .PCSrc(PCSrc), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  wire [16:0] act = {initial_sel, PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
                     RegWrite, ALUSrcA, PCSrc, ALUSrcB, ALUControl, illegal_o};

  function automatic logic [16:0] vec(bit init, bit pcw, bit iord, bit mw, bit irw,
                                      bit rd, bit m2r, bit rw, bit asa, bit pcs,
                                      logic [1:0] asb, logic [3:0] alu, bit ill);
    return {init, pcw, iord, mw, irw, rd, m2r, rw, asa, pcs, asb, alu, ill};
  endfunction

  function automatic bit funct_ok(input logic [5:0] fn, output logic [3:0] code);
    funct_ok = 1'b1;
    case (fn)
      6'h24:   code = 4'b0000;
      6'h25:   code = 4'b0001;
      6'h27:   code = 4'b0010;
      6'h20:   code = 4'b0100;
      6'h22:   code = 4'b0101;
      6'h2A:   code = 4'b0111;
      default: begin code = 4'b0100; funct_ok = 1'b0; end
    endcase
  endfunction

  // Reference model: the cycle-by-cycle output vectors of one instruction.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input bit z);
    logic [3:0] code;
    bit ok;
    exp_q.delete();
    exp_q.push_back(vec(init_done, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 4'b0100, 0));
    init_done = 1'b1;
    case (op)
      6'h23, 6'h2B: begin
        exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0100, 0));
        exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 4'b0100, 0));
        if (op == 6'h23) begin
          exp_q.push_back(vec(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0));
          exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 4'b0000, 0));
        end else begin
          exp_q.push_back(vec(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0));
        end
      end
      6'h00: begin
        ok = funct_ok(fn, code);
        exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0100, 0));
        exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, code, !ok));
        if (ok) exp_q.push_back(vec(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 4'b0000, 0));
      end
      6'h08: begin
        exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0100, 0));
        exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 4'b0100, 0));
        exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, 0));
      end
      6'h04: begin
        exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0100, 0));
        exp_q.push_back(vec(1, z, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 4'b0101, 0));
      end
      default: exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0100, 1));
    endcase
  endtask

  // Entered and left at posedge+1 of a FETCH cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input string name);
    int n;
    OP = op; Funct = fn; Zero = z;
    build(op, fn, z);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (act !== exp_q[i]) begin
        errors++;
        $display("FAIL %s op=%h fn=%h z=%0d cycle %0d: got %h expected %h",
                 name, op, fn, z, i, act, exp_q[i]);
      end
      checks++;
      if ((32'(MemWrite) + 32'(RegWrite) + 32'(IRWrite)) > 1) begin
        errors++;
        $display("FAIL %s write_exclusive cycle %0d: got mw=%0d rw=%0d irw=%0d expected at most one",
                 name, i, MemWrite, RegWrite, IRWrite);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_in_reset(input string name);
    checks++;
    if ({PCWrite, MemWrite, IRWrite, RegWrite, illegal_o, initial_sel} !== 6'b0) begin
      errors++;
      $display("FAIL %s: got pcw/mw/irw/rw/ill/init=%b expected 000000", name,
               {PCWrite, MemWrite, IRWrite, RegWrite, illegal_o, initial_sel});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    OP = 6'($urandom); Funct = 6'($urandom); Zero = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_in_reset("reset_hold");
    @(posedge clk); #1;
    reset = 1'b0;
    init_done = 1'b0;
  endtask

  task automatic test_addi();
    run_instr(6'h08, 6'($urandom), 1'($urandom), "addi");
    run_instr(6'h08, 6'($urandom), 1'($urandom), "addi_2nd");
  endtask

  task automatic test_rtype();
    logic [5:0] fns [6] = '{6'h22, 6'h24, 6'h25, 6'h27, 6'h20, 6'h2A};
    foreach (fns[i]) run_instr(6'h00, fns[i], 1'($urandom), "rtype");
  endtask

  task automatic test_mem();
    run_instr(6'h23, 6'($urandom), 1'($urandom), "lw");
    run_instr(6'h2B, 6'($urandom), 1'($urandom), "sw");
  endtask

  task automatic test_branch();
    run_instr(6'h04, 6'($urandom), 1'b1, "beq_taken");
    run_instr(6'h04, 6'($urandom), 1'b0, "beq_not_taken");
  endtask

  task automatic test_illegal();
    run_instr(6'h3F, 6'h20, 1'b0, "illegal_op");
    run_instr(6'h00, 6'h3F, 1'b0, "illegal_funct");
  endtask

  task automatic test_reset_mid();
    OP = 6'h23; Funct = 6'($urandom); Zero = 1'($urandom);
    build(6'h23, Funct, Zero);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      checks++;
      if (act !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_mid_pre cycle %0d: got %h expected %h", i, act, exp_q[i]);
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check_in_reset("reset_mid_hold");
    reset = 1'b0;
    init_done = 1'b0;
    run_instr(6'h23, 6'($urandom), 1'($urandom), "after_mid_reset");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [6];
    logic [5:0] fns [7];
    for (int k = 0; k < 200; k++) begin
      ops = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h04, 6'($urandom)};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'($urandom)};
      run_instr(ops[$urandom_range(0, 5)], fns[$urandom_range(0, 6)], 1'($urandom),
                "random");
    end
  endtask

  initial begin
    reset = 1'b1; OP = '0; Funct = '0; Zero = 1'b0; init_done = 1'b0;
    test_reset();
    test_addi();
    test_rtype();
    test_mem();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 32; datapath word width, documentation only, no effect on control logic.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 OP  input  6  opcode field from the datapath instruction register.
REQ-005 Funct  input  6  funct field from the datapath instruction register.
REQ-006 Zero  input  1  ALU zero flag from the datapath.
REQ-007 initial_sel  output  1  0 = PC source is the initial address; 1 = normal PC.
REQ-008 PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc  output  1 each  datapath strobes and selects.
REQ-009 ALUSrcB  output  2  00 = B reg, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-010 ALUControl  output  4  0000 AND, 0001 OR, 0010 NOR, 0100 ADD, 0101 SUB, 0111 SLT.
REQ-011 illegal_o  output  1  one-cycle pulse on an unsupported OP/Funct.

Function
REQ-012 Moore FSM; every state lasts exactly one clk; outputs depend on state only, except PCWrite in BRANCH and ALUControl in EXECUTE.
REQ-013 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, ADDIEXEC, ADDIWB, BRANCH.
REQ-014 FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, PCSrc=0, PCWrite=1; next DECODE.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=ADD (branch target into ALUOut); next by OP.
REQ-016 DECODE transitions: OP 0x23/0x2B -> MEMADR; 0x00 -> EXECUTE; 0x08 -> ADDIEXEC; 0x04 -> BRANCH; any other -> FETCH, with illegal_o=1 for that DECODE cycle.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ADD; next MEMREAD if OP=0x23, else MEMWRITE.
REQ-018 MEMREAD: IorD=1; next MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-019 MEMWRITE: IorD=1, MemWrite=1; next FETCH.
REQ-020 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct: 0x24 AND, 0x25 OR, 0x27 NOR, 0x20 ADD, 0x22 SUB, 0x2A SLT; next ALUWB.
REQ-021 Unsupported Funct in EXECUTE: ALUControl=ADD, illegal_o=1, next FETCH (ALUWB skipped, no register write).
REQ-022 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
REQ-023 ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ADD; next ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=1, PCWrite=Zero (combinational); next FETCH.
REQ-025 Any strobe not listed for a state (PCWrite, MemWrite, IRWrite, RegWrite, illegal_o) SHALL be 0; unlisted selects SHALL be 0.
REQ-026 Latency FETCH-to-FETCH: beq 3, R-type/addi/sw 4, lw 5 cycles.
REQ-027 initial_sel SHALL be 0 from reset until the end of the first FETCH cycle, then 1 until the next reset.
REQ-028 At most one of MemWrite, RegWrite, IRWrite SHALL be 1 in any cycle.

Reset
REQ-029 reset=1 at a rising edge SHALL force state=FETCH and initial_sel=0, regardless of current state (mid-instruction included); no partial write completes afterwards.
REQ-030 While reset=1, all write strobes (PCWrite, MemWrite, IRWrite, RegWrite) and illegal_o SHALL be 0.

Structure
REQ-031 Shared package SHALL hold the state encoding, OP/Funct constants and ALUControl codes, also used by the datapath and bench.
REQ-032 One combinational sub-module, alu_decoder (Funct -> ALUControl plus illegal flag), SHALL be instantiated; the FSM stays in multicycle_control_unit.

Verification
REQ-033 Reset, then OP=0x08: states FETCH(initial_sel=0), DECODE, ADDIEXEC(ALUSrcB=10, ALUControl=0100), ADDIWB(RegWrite=1, RegDst=0); initial_sel=1 from the 2nd cycle on.
REQ-034 OP=0x00, Funct=0x22: EXECUTE shows ALUSrcB=00, ALUControl=0101; ALUWB RegDst=1, RegWrite=1; back in FETCH on cycle 5.
REQ-035 OP=0x23: MEMADR, MEMREAD(IorD=1), MEMWB(MemtoReg=1, RegWrite=1); 5-cycle loop. OP=0x2B: MemWrite=1 for exactly one cycle; 4-cycle loop.
REQ-036 OP=0x04 with Zero=1 -> PCWrite=1, PCSrc=1 in BRANCH; Zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
REQ-037 OP=0x3F -> illegal_o=1 in DECODE only, no RegWrite/MemWrite, FETCH next; OP=0, Funct=0x3F -> illegal_o in EXECUTE, no write.
REQ-038 reset asserted during MEMADR of lw -> next cycle FETCH with initial_sel=0; MemWB RegWrite never asserted.
